meter_display: RTL and testbench
================================

Name: meter_display

Overview:
- Downstream output stage of the parking/traffic meter.
- Consumes the four BCD digits from the cascaded down-counter bank and drives a time-multiplexed 4-digit common-anode 7-segment display.
- Adds leading-zero suppression and status blinking: slow blink when remaining time is low, fast blink at zero.
- Timebases come from parameterised dividers on the single system clock.

Parameters:
- REFRESH_DIV, 100000, CLK cycles each digit is held before advancing to the next digit (>=2)
- HALF_DIV, 50000000, CLK cycles per half-second blink tick (>=2)
- LOW_SECS, 180, decimal threshold; a nonzero value below this is "low"

Ports:
- CLK  in  1  system clock, rising edge
- CLR  in  1  reset, synchronous, active-high
- Q1  in  4  BCD ones digit
- Q2  in  4  BCD tens digit
- Q3  in  4  BCD hundreds digit
- Q4  in  4  BCD thousands digit
- AN  out  4  anode enables, active-low; AN[0] = ones digit position
- SEG  out  7  segments, active-low, SEG[6:0] = g,f,e,d,c,b,a
- DP  out  1  decimal point, active-low; constant 1 (off)

Behaviour:
- Interface: one clock (CLK); reset CLR is synchronous and active-high.
- Reset (CLR=1 at a rising edge), all cleared in that cycle:
  - refresh counter = 0, digit select sel = 0
  - half-second counter = 0, phase (2-bit) = 0, stored mode = NORMAL
  - outputs AN = 4'b1111, SEG = 7'b1111111, DP = 1
  - CLR dominates all other activity; mid-scan reset restarts the scan at sel = 0.
- Refresh:
  - Counter counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, sel advances 0->1->2->3->0.
- Blink timebase:
  - Half counter counts 0..HALF_DIV-1; its wrap is a one-cycle tick.
  - Each tick increments phase, wrapping modulo 4.
- Mode, evaluated every cycle from Q1..Q4:
  - BAD if any digit > 9.
  - Else ZERO if all digits are 0.
  - Else LOW if decimal value (Q4*1000 + Q3*100 + Q2*10 + Q1) < LOW_SECS.
  - Else NORMAL.
- Mode change: if the evaluated mode differs from the stored mode, then on that edge:
  - stored mode updates
  - phase and half counter clear to 0, so a blink sequence always starts in the lit half
  - a tick coinciding with a mode change is discarded.
- Blanking (whole display dark, AN = 1111):
  - ZERO: blank when phase[0] = 1 (0.5 s on / 0.5 s off).
  - LOW: blank when phase[1] = 1 (1 s on / 1 s off).
  - NORMAL and BAD: never blank.
- Leading-zero suppression, per position:
  - Position sel > 0 is dark if it and every higher digit are 0.
  - The ones digit is always lit unless the display is blanked.
  - Suppression does not apply in BAD mode.
- Output:
  - When not dark: AN = ~(4'b0001 << sel); SEG = encoding of the selected digit.
  - When dark: AN = 1111, SEG = 1111111.
  - AN and SEG are registered, one cycle after the sel/input change that produces them.
- Segment encoding (hex, SEG[6:0]):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - digit > 9 = 3F (dash)
  - blank = 7F
- Inputs may change on any cycle; no handshake. The display reflects inputs sampled one cycle earlier.

Decomposition:
- Shared package meter_pkg:
  - mode encoding (NORMAL, LOW, ZERO, BAD; 2 bits)
  - segment constants SEG_BLANK = 7F and SEG_DASH = 3F
  - the 0-9 segment table
- One natural sub-module: bcd_to_seg, a combinational 4-bit BCD to 7-bit active-low decoder with dash for >9.
- Dividers, mode logic and scan stay in meter_display.

Test Plan (REFRESH_DIV=4, HALF_DIV=16, LOW_SECS=180):
- Reset: CLR high 2 cycles with Q=1,2,3,4 -> AN=1111, SEG=7F, DP=1. After release, sel=0 drives AN=1110, SEG=19 within 1 cycle, and AN=1101, SEG=30 after 4 further cycles.
- Normal scan: Q4..Q1 = 0,2,5,0 (250) -> over 16 cycles AN cycles 1110 / 1101 / 1011 / 1111. SEG for the three lit digits is 40, 12, 24. Thousands suppressed; never blanks.
- Low blink: Q = 0,1,7,9 (179) -> lit for 32 cycles, dark for 32, repeating. Switching to 180 mid-dark relights on the next cycle and stays lit.
- Zero blink: all zero -> ones digit shows 40 for 16 cycles, dark 16, repeating. Other positions always dark.
- Mode change: step from 179 to 000 at an arbitrary cycle -> phase restarts, display lit for the first 16 cycles after the change. A coincident tick is ignored.
- Invalid digit: Q2 = 4'hC, others 0 -> mode BAD, no blinking, no suppression. Tens position shows 3F; other positions show 40.

Source files
------------

// File: rtl/meter_pkg.sv
// ---------------------------------------------------------------------------
// meter_pkg
// Shared definitions for the meter display output stage.
//   mode_t     : display status mode (NORMAL, LOW, ZERO, BAD), 2 bits
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DASH   : only segment g lit, shown for a non-BCD digit
//   SEG_TABLE  : active-low g..a patterns for the decimal digits 0-9
//   is_bcd()   : true when a 4-bit value is a legal decimal digit
// ---------------------------------------------------------------------------
package meter_pkg;

    // Display status. Priority when classifying is BAD > ZERO > LOW > NORMAL.
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_LOW    = 2'd1,
        MODE_ZERO   = 2'd2,
        MODE_BAD    = 2'd3
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   digit  in  4  BCD digit; values above 9 are treated as invalid
//   seg    out 7  active-low segments {g,f,e,d,c,b,a}; dash for invalid input
// ---------------------------------------------------------------------------
module bcd_to_seg
    import meter_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // A non-BCD code cannot be shown as a number, so a dash marks it
    // visibly instead of showing some arbitrary pattern.
    always_comb begin
        seg = SEG_DASH;
        if (is_bcd(digit)) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/meter_display.sv
// ---------------------------------------------------------------------------
// meter_display
// Output stage of the parking/traffic meter. Scans the four BCD digits of
// the down-counter bank onto a multiplexed common-anode 4-digit display,
// suppresses leading zeros and blinks the whole display when time is low
// (1 s on / 1 s off) or expired (0.5 s on / 0.5 s off).
// Parameters:
//   REFRESH_DIV  clock cycles each digit position is held (>= 2)
//   HALF_DIV     clock cycles per half-second blink tick (>= 2)
//   LOW_SECS     nonzero values below this count as "low"
// Ports:
//   CLK  in  1  system clock, rising edge
//   CLR  in  1  synchronous active-high reset
//   Q1   in  4  BCD ones digit
//   Q2   in  4  BCD tens digit
//   Q3   in  4  BCD hundreds digit
//   Q4   in  4  BCD thousands digit
//   AN   out 4  anode enables, active-low, AN[0] = ones position
//   SEG  out 7  segments, active-low, {g,f,e,d,c,b,a}
//   DP   out 1  decimal point, active-low, always off
// ---------------------------------------------------------------------------
module meter_display
    import meter_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int HALF_DIV    = 50000000,
    parameter int LOW_SECS    = 180
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] Q1,
    input  logic [3:0] Q2,
    input  logic [3:0] Q3,
    input  logic [3:0] Q4,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HALF_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
    localparam logic [HALF_W-1:0]    HALF_LAST    = HALF_W'(HALF_DIV - 1);

    logic [REFRESH_W-1:0] refresh_cnt;
    logic [REFRESH_W-1:0] refresh_cnt_next;
    logic [1:0]           sel;
    logic [1:0]           sel_next;
    logic [HALF_W-1:0]    half_cnt;
    logic [HALF_W-1:0]    half_cnt_next;
    logic [1:0]           phase;
    logic [1:0]           phase_next;
    mode_t                mode_q;
    mode_t                mode_eval;
    logic                 mode_change;
    logic [1:0]           eff_phase;

    logic [13:0]          dec_value;
    logic [3:0]           digits [4];
    logic [3:0]           lead_zero;
    logic [3:0]           sel_digit;
    logic [6:0]           sel_seg;
    logic                 blank;
    logic                 dark;
    logic [3:0]           an_next;
    logic [6:0]           seg_next;

    // The decimal point is never used by the meter.
    assign DP = 1'b1;

    // Binary value of the four digits. Only meaningful when every digit is
    // BCD, which is the only case in which the LOW comparison is consulted,
    // and then the result (at most 9999) always fits in 14 bits.
    assign dec_value = 14'(Q4) * 14'd1000 + 14'(Q3) * 14'd100
                     + 14'(Q2) * 14'd10 + 14'(Q1);

    // Classify the current inputs every cycle. A corrupt digit outranks
    // everything so a fault is never mistaken for expired or low time.
    always_comb begin
        mode_eval = MODE_NORMAL;
        if (!is_bcd(Q1) || !is_bcd(Q2) || !is_bcd(Q3) || !is_bcd(Q4)) begin
            mode_eval = MODE_BAD;
        end else if ((Q1 == 4'd0) && (Q2 == 4'd0) && (Q3 == 4'd0) && (Q4 == 4'd0)) begin
            mode_eval = MODE_ZERO;
        end else if (int'(dec_value) < LOW_SECS) begin
            mode_eval = MODE_LOW;
        end
    end

    assign mode_change = (mode_eval != mode_q);

    // On the edge where the mode changes, the blink phase is already treated
    // as restarted so the new mode begins in its lit half straight away.
    assign eff_phase = mode_change ? 2'd0 : phase;

    // Next-state logic for the scan divider, blink divider and phase.
    // A mode change restarts the blink timebase and swallows any tick that
    // lands on the same edge, so every blink sequence starts lit.
    always_comb begin
        refresh_cnt_next = refresh_cnt + REFRESH_W'(1);
        sel_next         = sel;
        half_cnt_next    = half_cnt + HALF_W'(1);
        phase_next       = phase;

        if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt_next = '0;
            sel_next         = sel + 2'd1;
        end

        if (mode_change) begin
            half_cnt_next = '0;
            phase_next    = 2'd0;
        end else if (half_cnt == HALF_LAST) begin
            half_cnt_next = '0;
            phase_next    = phase + 2'd1;
        end
    end

    // Leading-zero detection: lead_zero[i] is set when position i and all
    // positions above it hold zero. The ones position is never suppressed.
    always_comb begin
        digits[0]    = Q1;
        digits[1]    = Q2;
        digits[2]    = Q3;
        digits[3]    = Q4;
        lead_zero[3] = (Q4 == 4'd0);
        lead_zero[2] = (Q3 == 4'd0) && lead_zero[3];
        lead_zero[1] = (Q2 == 4'd0) && lead_zero[2];
        lead_zero[0] = 1'b0;
    end

    assign sel_digit = digits[sel];

    bcd_to_seg u_bcd_to_seg (
        .digit (sel_digit),
        .seg   (sel_seg)
    );

    // Decide whether the currently scanned position is dark, either because
    // the whole display is in the off half of a blink or because the digit
    // is a leading zero. A BAD reading is shown in full so the faulty digit
    // position is always visible.
    always_comb begin
        blank = 1'b0;
        unique case (mode_eval)
            MODE_ZERO: blank = eff_phase[0];
            MODE_LOW:  blank = eff_phase[1];
            default:   blank = 1'b0;
        endcase

        dark = blank || ((mode_eval != MODE_BAD) && lead_zero[sel]);

        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        if (!dark) begin
            an_next  = ~(4'b0001 << sel);
            seg_next = sel_seg;
        end
    end

    // State and output registers. Reset clears the timebases, restarts the
    // scan at the ones position and turns the display fully off.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            refresh_cnt <= '0;
            sel         <= 2'd0;
            half_cnt    <= '0;
            phase       <= 2'd0;
            mode_q      <= MODE_NORMAL;
            AN          <= 4'b1111;
            SEG         <= SEG_BLANK;
        end else begin
            refresh_cnt <= refresh_cnt_next;
            sel         <= sel_next;
            half_cnt    <= half_cnt_next;
            phase       <= phase_next;
            mode_q      <= mode_eval;
            AN          <= an_next;
            SEG         <= seg_next;
        end
    end

endmodule

// File: tb/tb_meter_display.sv
// ---------------------------------------------------------------------------
// tb_meter_display
// Self-checking bench for meter_display with small dividers. A reference
// model derives the expected display from elapsed-cycle timestamps and the
// digit rules, pushes it into a queue on every rising edge, and a separate
// monitor pops and compares against the registered outputs on falling edges.
// ---------------------------------------------------------------------------
module tb_meter_display;

    localparam int REFRESH_DIV = 4;
    localparam int HALF_DIV    = 16;
    localparam int LOW_SECS    = 180;

    logic       clk;
    logic       clr;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [3:0] q4;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int compared   = 0;
    int mismatched = 0;

    // Expected {AN, SEG, DP} for each rising edge, oldest first.
    logic [11:0] expect_q [$];

    meter_display #(
        .REFRESH_DIV (REFRESH_DIV),
        .HALF_DIV    (HALF_DIV),
        .LOW_SECS    (LOW_SECS)
    ) dut (
        .CLK (clk),
        .CLR (clr),
        .Q1  (q1),
        .Q2  (q2),
        .Q3  (q3),
        .Q4  (q4),
        .AN  (an),
        .SEG (seg),
        .DP  (dp)
    );

    // 10 time-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment patterns for the digits 0-9, {g..a} active-low.
    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] table_v [10];
        table_v = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 9) return 7'h3F;
        return table_v[d];
    endfunction

    // Mode codes used only by the model: 0 normal, 1 low, 2 zero, 3 bad.
    function automatic int classify(input int d0, input int d1, input int d2, input int d3);
        if (d0 > 9 || d1 > 9 || d2 > 9 || d3 > 9) return 3;
        if (d0 + d1 + d2 + d3 == 0) return 2;
        if (d3 * 1000 + d2 * 100 + d1 * 10 + d0 < LOW_SECS) return 1;
        return 0;
    endfunction

    // Reference model state expressed as timestamps: the edge on which the
    // scan last restarted, the edge on which the blink last restarted, and
    // the mode the display was last showing.
    int edge_no     = 0;
    int scan_origin = 0;
    int blink_start = 0;
    int shown_mode  = 0;

    always @(posedge clk) begin
        int d [4];
        int m;
        int pos;
        int half_periods;
        bit is_dark;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;

        edge_no = edge_no + 1;
        d[0] = int'(q1);
        d[1] = int'(q2);
        d[2] = int'(q3);
        d[3] = int'(q4);

        if (clr) begin
            scan_origin = edge_no;
            blink_start = edge_no;
            shown_mode  = 0;
            expect_q.push_back({4'b1111, 7'h7F, 1'b1});
        end else begin
            m = classify(d[0], d[1], d[2], d[3]);
            if (m != shown_mode) begin
                blink_start = edge_no;
                shown_mode  = m;
            end
            // The position lit on this edge is the one selected during the
            // preceding cycles; REFRESH_DIV edges per position after reset.
            pos = ((edge_no - scan_origin - 1) / REFRESH_DIV) % 4;
            // Whole half-second periods elapsed since the blink restarted.
            if (edge_no == blink_start) half_periods = 0;
            else half_periods = (edge_no - blink_start - 1) / HALF_DIV;

            is_dark = 1'b0;
            if (m == 2 && (half_periods % 2) == 1) is_dark = 1'b1;
            if (m == 1 && (half_periods % 4) >= 2) is_dark = 1'b1;
            if (m != 3 && pos > 0) begin
                bit all_zero;
                all_zero = 1'b1;
                for (int p = pos; p < 4; p++) if (d[p] != 0) all_zero = 1'b0;
                if (all_zero) is_dark = 1'b1;
            end

            if (is_dark) begin
                exp_an  = 4'b1111;
                exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(4'b0001 << pos);
                exp_seg = seg_of(d[pos]);
            end
            expect_q.push_back({exp_an, exp_seg, 1'b1});
        end
    end

    // Monitor: after each rising edge has registered its output, compare
    // the DUT against the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [11:0] want;
        if (expect_q.size() != 0) begin
            want = expect_q.pop_front();
            check_output(want);
        end
    end

    task automatic check_output(input logic [11:0] want);
        compared = compared + 1;
        if ({an, seg, dp} !== want) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL display @%0t: got AN=%b SEG=%h DP=%b, want AN=%b SEG=%h DP=%b",
                     $time, an, seg, dp, want[11:8], want[7:1], want[0]);
        end
    endtask

    // Hold the given reset level and digits (thousands first) for n cycles.
    task automatic apply_stimulus(input logic r, input logic [3:0] t4, input logic [3:0] t3,
                                  input logic [3:0] t2, input logic [3:0] t1, input int n);
        @(negedge clk);
        clr = r;
        q4  = t4;
        q3  = t3;
        q2  = t2;
        q1  = t1;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        int v;
        int kind;
        logic [3:0] r4, r3, r2, r1;

        clr = 1'b1;
        q4 = 4'd1; q3 = 4'd2; q2 = 4'd3; q1 = 4'd4;

        // Reset with 1234 presented, then release and watch the scan start.
        apply_stimulus(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 2);
        apply_stimulus(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 12);

        // Normal value with a suppressed thousands digit.
        apply_stimulus(1'b0, 4'd0, 4'd2, 4'd5, 4'd0, 40);

        // Low value blinking, then relit by crossing the threshold mid-dark.
        apply_stimulus(1'b0, 4'd0, 4'd1, 4'd7, 4'd9, 100);
        apply_stimulus(1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 20);

        // Expired time blinking.
        apply_stimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 80);

        // Low to zero at a sweep of change points, some coinciding with a tick.
        for (int i = 10; i < 26; i++) begin
            apply_stimulus(1'b0, 4'd0, 4'd1, 4'd7, 4'd9, i);
            apply_stimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 20);
        end

        // Invalid tens digit: no blinking, no suppression, dash shown.
        apply_stimulus(1'b0, 4'd0, 4'd0, 4'hC, 4'd0, 30);

        // Mid-scan reset restarts the scan at the ones position.
        apply_stimulus(1'b0, 4'd9, 4'd8, 4'd7, 4'd6, 6);
        apply_stimulus(1'b1, 4'd9, 4'd8, 4'd7, 4'd6, 1);
        apply_stimulus(1'b0, 4'd9, 4'd8, 4'd7, 4'd6, 20);

        // Randomised values of every class, held for random durations.
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 5));
            v    = 0;
            case (kind)
                0: v = 0;
                1: v = int'($urandom_range(1, LOW_SECS - 1));
                2: v = int'($urandom_range(LOW_SECS, 9999));
                3: v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, 9999));
            endcase
            r4 = 4'(v / 1000);
            r3 = 4'((v / 100) % 10);
            r2 = 4'((v / 10) % 10);
            r1 = 4'(v % 10);
            if (kind == 4) begin
                r4 = 4'($urandom_range(0, 15));
                r2 = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 14) == 0) begin
                apply_stimulus(1'b1, r4, r3, r2, r1, int'($urandom_range(1, 3)));
            end
            apply_stimulus(1'b0, r4, r3, r2, r1, int'($urandom_range(1, 40)));
        end

        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
